// File: rtl/memory_access_controller_pkg.sv
// Shared types and defaults for the memory access controller: FSM state
// encoding, default bus widths and the wait-timer width helper.
package mac_pkg;

   typedef enum logic [1:0] {
      MAC_IDLE   = 2'd0,
      MAC_ACCESS = 2'd1,
      MAC_RESP   = 2'd2
   } mac_state_t;

   localparam int MAC_ADDR_W  = 16;
   localparam int MAC_DATA_W  = 16;
   localparam int MAC_TIMEOUT = 255;

   // Counter must hold TIMEOUT itself; a disabled timer still needs one bit.
   function automatic int mac_timer_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/memory_access_controller_if.sv
// Datapath request/response channel plus the memory port, bundled so the
// controller sees one slave view and the driver/memory side one master view.
interface memory_access_controller_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata, mem_ack,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata, mem_ack,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/memory_access_controller_wait_timer.sv
// Wait-state counter for the ACCESS phase: cleared on request accept,
// counts while enabled, saturates, and flags the last allowed cycle.
module mac_wait_timer
   import mac_pkg::*;
#(
   parameter int TIMEOUT = MAC_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int TW = mac_timer_width(TIMEOUT);

   logic [TW-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i && (count_q != {TW{1'b1}})) begin
         count_q <= count_q + TW'(1);
      end
   end

   // Asserted during the TIMEOUT-th ACCESS cycle so the abort lands on its closing edge.
   assign expired_o = (TIMEOUT != 0) && (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access_controller.sv
// Single-outstanding memory bus sequencer: IDLE -> ACCESS -> RESP, with the
// MDR capturing read data and a wait-state timeout that reports rsp_err.
module memory_access_controller
   import mac_pkg::*;
#(
   parameter int ADDR_W  = MAC_ADDR_W,
   parameter int DATA_W  = MAC_DATA_W,
   parameter int TIMEOUT = MAC_TIMEOUT
) (
   input logic                       clk,
   input logic                       reset,
   memory_access_controller_if.slave bus
);

   mac_state_t        state_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] mdr_q;

   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   assign timer_clear  = (state_q == MAC_IDLE) && bus.req_valid;
   assign timer_enable = (state_q == MAC_ACCESS) && !bus.mem_ack;

   mac_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (timer_clear),
      .enable_i  (timer_enable),
      .expired_o (timer_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= MAC_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mdr_q       <= '0;
      end else begin
         case (state_q)
            MAC_IDLE: begin
               if (bus.req_valid) begin
                  mem_addr_q  <= bus.req_addr;
                  mem_wdata_q <= bus.req_wdata;
                  mem_we_q    <= bus.req_write;
                  mem_en_q    <= 1'b1;
                  req_ready_q <= 1'b0;
                  state_q     <= MAC_ACCESS;
               end
            end
            MAC_ACCESS: begin
               // An ack in the expiry cycle still completes the access cleanly.
               if (bus.mem_ack) begin
                  if (!mem_we_q) begin
                     mdr_q <= bus.mem_rdata;
                  end
                  rsp_err_q   <= 1'b0;
                  mem_en_q    <= 1'b0;
                  mem_we_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= MAC_RESP;
               end else if (timer_expired) begin
                  rsp_err_q   <= 1'b1;
                  mem_en_q    <= 1'b0;
                  mem_we_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= MAC_RESP;
               end
            end
            MAC_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= MAC_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               mem_en_q    <= 1'b0;
               mem_we_q    <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= MAC_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = mdr_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench for memory_access_controller with TIMEOUT=4: a vector table of
// transactions plus hand sequences for asynchronous reset mid-transaction.
module tb_memory_access_controller;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   memory_access_controller_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   memory_access_controller #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .TIMEOUT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          ack_at;
      int          rsp_wait;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_en;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      int en_cnt;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_write = v.wr;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      step();
      bus.req_valid = 1'b0;
      bus.req_write = ~v.wr;
      bus.req_addr  = ~v.addr;
      bus.req_wdata = ~v.wdata;
      chk("mem_en_after_accept", 32'(bus.mem_en), 32'd1);
      chk("mem_we_after_accept", 32'(bus.mem_we), 32'(v.wr));
      chk("mem_addr", 32'(bus.mem_addr), 32'(v.addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(v.wdata));
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      en_cnt = 0;
      for (int c = 0; c < 20 && bus.mem_en === 1'b1; c++) begin
         en_cnt++;
         if (bus.mem_addr !== v.addr || bus.mem_we !== v.wr) begin
            chk("mem_addr_we_stable", {bus.mem_we, 15'd0, bus.mem_addr}, {v.wr, 15'd0, v.addr});
         end
         if (c == v.ack_at) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.rdata;
         end
         step();
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 16'h0000;
      end
      chk("mem_en_cycles", 32'(en_cnt), 32'(v.exp_en));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
      chk("mem_we_after_access", 32'(bus.mem_we), 32'd0);
      // Late ack while the response is pending must not touch the MDR.
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hDEAD;
      step();
      bus.mem_ack   = 1'b0;
      chk("rsp_rdata_late_ack", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
      chk("rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
      for (int w = 0; w < v.rsp_wait; w++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = 16'h0BAD;
         step();
         chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("stall_rsp_rdata", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
         chk("stall_rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
         chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
         chk("stall_mem_en", 32'(bus.mem_en), 32'd0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
      chk("rsp_err_after_hs", 32'(bus.rsp_err), 32'd0);
      chk("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hDEAD;
      step();
      bus.mem_ack   = 1'b0;
      chk("rsp_rdata_idle_ack", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
      chk("mem_en_idle", 32'(bus.mem_en), 32'd0);
      $display("txn %0d: %s addr=%h en_cycles=%0d rdata=%h err=%0d", idx,
               v.wr ? "WR" : "RD", v.addr, en_cnt, bus.rsp_rdata, v.exp_err);
   endtask

   initial begin
      vec_t extra;
      checks = 0;
      errors = 0;
      //          wr    addr      wdata     rdata     ack rwait exp_rdata err  en
      vecs[0] = '{1'b0, 16'h0040, 16'h0000, 16'hBEEF, 2,  0,    16'hBEEF, 1'b0, 3};
      vecs[1] = '{1'b1, 16'h0100, 16'h1234, 16'h5555, 0,  0,    16'hBEEF, 1'b0, 1};
      vecs[2] = '{1'b0, 16'h0200, 16'h0000, 16'hA5A5, 0,  5,    16'hA5A5, 1'b0, 1};
      vecs[3] = '{1'b0, 16'h0300, 16'h0000, 16'h9999, 99, 0,    16'hA5A5, 1'b1, 4};
      vecs[4] = '{1'b0, 16'h0400, 16'h0000, 16'hC3C3, 3,  0,    16'hC3C3, 1'b0, 4};
      vecs[5] = '{1'b1, 16'h0500, 16'hFFFF, 16'h7777, 1,  2,    16'hC3C3, 1'b0, 2};
      vecs[6] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0001, 1,  0,    16'h0001, 1'b0, 2};

      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = 16'h0000;
      bus.req_wdata = 16'h0000;
      bus.rsp_ready = 1'b0;
      bus.mem_rdata = 16'h0000;
      bus.mem_ack   = 1'b0;
      #12;
      chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("reset_mem_en", 32'(bus.mem_en), 32'd0);
      chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
      chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("reset_mdr", 32'(bus.rsp_rdata), 32'd0);
      step();
      reset = 1'b1;
      step();

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i], i);
      end

      // Asynchronous reset while the memory access is outstanding.
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 16'h0AAA;
      step();
      bus.req_valid = 1'b0;
      step();
      chk("rst_access_mem_en_before", 32'(bus.mem_en), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_access_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_access_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_access_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_access_mdr", 32'(bus.rsp_rdata), 32'd0);
      step();
      reset = 1'b1;
      step();
      chk("rst_access_idle_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_access_idle_rsp", 32'(bus.rsp_valid), 32'd0);
      $display("txn reset-in-access: mem_en=%0d rsp_valid=%0d req_ready=%0d",
               bus.mem_en, bus.rsp_valid, bus.req_ready);

      // Asynchronous reset while the response is waiting for rsp_ready.
      bus.req_valid = 1'b1;
      bus.req_addr  = 16'h0BBB;
      step();
      bus.req_valid = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h1111;
      step();
      bus.mem_ack   = 1'b0;
      chk("rst_resp_rsp_valid_before", 32'(bus.rsp_valid), 32'd1);
      chk("rst_resp_rdata_before", 32'(bus.rsp_rdata), 32'h1111);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_resp_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_resp_mdr", 32'(bus.rsp_rdata), 32'd0);
      step();
      reset = 1'b1;
      bus.rsp_ready = 1'b1;
      step();
      step();
      bus.rsp_ready = 1'b0;
      chk("rst_resp_no_response", 32'(bus.rsp_valid), 32'd0);
      chk("rst_resp_idle_ready", 32'(bus.req_ready), 32'd1);
      $display("txn reset-in-resp: rsp_valid=%0d req_ready=%0d", bus.rsp_valid, bus.req_ready);

      extra = '{1'b0, 16'h1234, 16'h0000, 16'h4242, 0, 1, 16'h4242, 1'b0, 1};
      run_txn(extra, 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule
